// File: rtl/spi_master_framed_pkg.sv
// Shared types and helpers for the framed SPI master.
// Holds the FSM state encoding, the out-of-band byte width and the MOSI bit picker.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        NEXT,
        HOLD
    } spi_state_t;

    localparam int OOB_W = 8;

    // LSB-first words are shifted toward bit 0; MSB-first words are indexed by the remaining-bit count.
    function automatic logic bit_sel(input logic [63:0] data, input logic [6:0] idx, input logic lsb_first);
        return lsb_first ? data[0] : data[idx];
    endfunction

endpackage

// File: rtl/spi_master_framed_half_timer.sv
// Half-period down-counter for the SPI master.
// It reloads on every phase change and flags the last cycle of each phase.
module spi_half_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/spi_master_framed.sv
// SPI master shifting framed words or out-of-band bytes over a shared cs/frame pin pair.
// Back-to-back requests accepted in NEXT continue the open cs/frame window without a setup gap.
module spi_master_framed
    import spi_master_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CLK_DIV   = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_oob,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              err,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs,
    output logic              spi_frame
);

    localparam int   CNT_W = $clog2(WORD_W + 1);
    localparam logic LSB   = (LSB_FIRST != 0);

    spi_state_t state_q, state_d;

    logic [WORD_W-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [WORD_W-1:0] tx_shift, load_data;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, load_bits;
    logic              oob_q, oob_d, last_q, last_d;
    logic              spi_clk_q, spi_clk_d, mosi_q, mosi_d;
    logic              cs_q, cs_d, frame_q, frame_d;
    logic              rx_valid_q, rx_valid_d, err_q, err_d;
    logic              accept, oob_reject, start;
    logic              timer_load, timer_expire;

    spi_half_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .expire(timer_expire)
    );

    assign timer_load = (state_d != state_q);
    assign accept     = tx_valid && tx_ready;
    // An OOB byte cannot join a series of framed words; it is swallowed and flagged.
    assign oob_reject = accept && (state_q == NEXT) && tx_oob && !frame_q;
    assign start      = accept && !oob_reject;
    assign load_data  = tx_oob ? WORD_W'(tx_data[OOB_W-1:0]) : tx_data;
    assign load_bits  = tx_oob ? CNT_W'(OOB_W) : CNT_W'(WORD_W);
    assign tx_shift   = LSB ? (tx_q >> 1) : tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (timer_expire) state_d = LOW;
            LOW:     if (timer_expire) state_d = HIGH;
            HIGH:    if (timer_expire) state_d = (bit_cnt_q == CNT_W'(1)) ? NEXT : LOW;
            NEXT: begin
                if (last_q) begin
                    state_d = HOLD;
                end else if (start) begin
                    state_d = (frame_q && !tx_oob) ? SETUP : LOW;
                end
            end
            HOLD:    if (timer_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == IDLE) || ((state_q == NEXT) && !last_q);
        busy     = (state_q != IDLE);
    end

    always_comb begin
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        oob_d      = oob_q;
        last_d     = last_q;
        spi_clk_d  = spi_clk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        frame_d    = frame_q;
        rx_valid_d = 1'b0;
        err_d      = oob_reject;
        if (start) begin
            tx_d      = load_data;
            rx_d      = '0;
            bit_cnt_d = load_bits;
            oob_d     = tx_oob;
            last_d    = tx_last;
            cs_d      = 1'b0;
            frame_d   = tx_oob;
            mosi_d    = bit_sel(64'(load_data), 7'(load_bits - 1'b1), LSB);
        end
        case (state_q)
            LOW: begin
                if (timer_expire) begin
                    spi_clk_d = 1'b1;
                    rx_d      = LSB ? {spi_miso, rx_q[WORD_W-1:1]} : {rx_q[WORD_W-2:0], spi_miso};
                end
            end
            HIGH: begin
                if (timer_expire) begin
                    spi_clk_d = 1'b0;
                    if (bit_cnt_q == CNT_W'(1)) begin
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tx_d      = tx_shift;
                        mosi_d    = bit_sel(64'(tx_shift), 7'(bit_cnt_q - CNT_W'(2)), LSB);
                    end
                end
            end
            HOLD: begin
                if (timer_expire) begin
                    cs_d    = 1'b1;
                    frame_d = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            oob_q      <= 1'b0;
            last_q     <= 1'b0;
            spi_clk_q  <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            frame_q    <= 1'b1;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            oob_q      <= oob_d;
            last_q     <= last_d;
            spi_clk_q  <= spi_clk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            frame_q    <= frame_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    // LSB-first OOB bytes land in the top byte of the right-shifting receiver.
    assign rx_data   = (oob_q && LSB) ? (rx_q >> (WORD_W - OOB_W)) : rx_q;
    assign rx_valid  = rx_valid_q;
    assign err       = err_q;
    assign spi_clk   = spi_clk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs    = cs_q;
    assign spi_frame = frame_q;

endmodule

// File: tb/tb_spi_master_framed.sv
// Bench for spi_master_framed: a loopback LSB-first instance and an MSB-first instance with miso held high.
// Expected words, latencies and bit streams come from a transfer-level model of the protocol.
module tb_spi_master_framed;

    localparam int W  = 32;
    localparam int CA = 2;
    localparam int CB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          tx_valid_a = 1'b0, tx_oob_a = 1'b0, tx_last_a = 1'b0;
    logic [W-1:0]  tx_data_a = '0;
    logic          tx_ready_a, rx_valid_a, err_a, busy_a, spi_clk_a, mosi_a, cs_a, frame_a;
    logic [W-1:0]  rx_data_a;

    logic          tx_valid_b = 1'b0, tx_oob_b = 1'b0, tx_last_b = 1'b0;
    logic [W-1:0]  tx_data_b = '0;
    logic          tx_ready_b, rx_valid_b, err_b, busy_b, spi_clk_b, mosi_b, cs_b, frame_b;
    logic [W-1:0]  rx_data_b;

    spi_master_framed #(.WORD_W(W), .CLK_DIV(CA), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
        .tx_oob(tx_oob_a), .tx_last(tx_last_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .err(err_a), .busy(busy_a), .spi_clk(spi_clk_a), .spi_mosi(mosi_a), .spi_miso(mosi_a),
        .spi_cs(cs_a), .spi_frame(frame_a)
    );

    spi_master_framed #(.WORD_W(W), .CLK_DIV(CB), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
        .tx_oob(tx_oob_b), .tx_last(tx_last_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .err(err_b), .busy(busy_b), .spi_clk(spi_clk_b), .spi_mosi(mosi_b), .spi_miso(1'b1),
        .spi_cs(cs_b), .spi_frame(frame_b)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Pin monitors, sampled shortly after each clock edge.
    int   aRises = 0, aRiseFrameHigh = 0, aFrameLowCycles = 0, aFrameRises = 0;
    logic aPrevClk = 1'b0, aPrevFrame = 1'b1;
    logic aBits[$];
    int   bRises = 0, bHiRun = 0, bHiMin = 1000, bHiMax = 0, bUnstable = 0;
    logic bPrevClk = 1'b0, bHiMosi = 1'b0;
    logic bBits[$];

    always @(posedge clk) begin
        #2;
        if (spi_clk_a === 1'b1 && aPrevClk !== 1'b1) begin
            aRises++;
            aBits.push_back(mosi_a);
            if (frame_a === 1'b1) aRiseFrameHigh++;
        end
        if (frame_a === 1'b0) aFrameLowCycles++;
        if (frame_a === 1'b1 && aPrevFrame === 1'b0) aFrameRises++;
        aPrevClk   = spi_clk_a;
        aPrevFrame = frame_a;
    end

    always @(posedge clk) begin
        #2;
        if (spi_clk_b === 1'b1) begin
            if (bPrevClk !== 1'b1) begin
                bRises++;
                bBits.push_back(mosi_b);
                bHiRun  = 1;
                bHiMosi = mosi_b;
            end else begin
                bHiRun++;
                if (mosi_b !== bHiMosi) bUnstable++;
            end
        end else if (bPrevClk === 1'b1) begin
            if (bHiRun < bHiMin) bHiMin = bHiRun;
            if (bHiRun > bHiMax) bHiMax = bHiRun;
        end
        bPrevClk = spi_clk_b;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input bit useB, input logic [W-1:0] data, input bit oob, input bit last);
        int guard = 0;
        while (!(useB ? tx_ready_b : tx_ready_a) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) checkOutput("ready_timeout", 0, 1);
        if (useB) begin
            tx_valid_b = 1'b1; tx_data_b = data; tx_oob_b = oob; tx_last_b = last;
        end else begin
            tx_valid_a = 1'b1; tx_data_a = data; tx_oob_a = oob; tx_last_a = last;
        end
        @(posedge clk);
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic waitRx(input bit useB, input string tag, output logic [W-1:0] data, output int lat);
        lat = 1;
        while (!(useB ? rx_valid_b : rx_valid_a) && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 5000) checkOutput({tag, "_rx_timeout"}, 0, 1);
        data = useB ? rx_data_b : rx_data_a;
    endtask

    task automatic waitIdle(input bit useB);
        int guard = 0;
        while ((useB ? busy_b : busy_a) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) checkOutput("idle_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] assemble(input bit useB, input int startIdx, input int n, input bit lsb);
        logic [W-1:0] v = '0;
        logic         b;
        for (int i = 0; i < n; i++) begin
            b = useB ? bBits[startIdx + i] : aBits[startIdx + i];
            if (lsb) v[i] = b;
            else     v = {v[W-2:0], b};
        end
        return v;
    endfunction

    function automatic int expLatency(input int c, input int nbits, input bit setup);
        return (setup ? c : 0) + 2 * c * nbits + 1;
    endfunction

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] d, d2, got;
        int           lat, r0, q0, f0, j;
        bit           open, openOob, oob, last;

        repeat (3) @(negedge clk);
        checkOutput("reset_cs", cs_a, 1);
        checkOutput("reset_frame", frame_a, 1);
        checkOutput("reset_sclk", spi_clk_a, 0);
        checkOutput("reset_mosi", mosi_a, 0);
        checkOutput("reset_ready", tx_ready_a, 1);
        checkOutput("reset_busy_rxv_err", {busy_a, rx_valid_a, err_a}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single framed word in loopback.
        r0 = aRises; q0 = aBits.size(); f0 = aRiseFrameHigh;
        applyStimulus(0, 32'hA5A51234, 0, 1);
        waitRx(0, "word", got, lat);
        checkOutput("word_rx", got, 32'hA5A51234);
        checkOutput("word_latency", lat, expLatency(CA, 32, 1));
        checkOutput("word_rises", aRises - r0, 32);
        checkOutput("word_bits", assemble(0, q0, 32, 1), 32'hA5A51234);
        checkOutput("word_frame_low_at_rises", aRiseFrameHigh - f0, 0);
        j = 0;
        while (!cs_a && j < 100) begin
            @(negedge clk);
            j++;
        end
        checkOutput("cs_release_delay", j, CA + 1);
        checkOutput("frame_release", frame_a, 1);
        checkOutput("idle_after_word", {busy_a, tx_ready_a}, 2'b01);

        // Out-of-band byte: upper data bits must be ignored.
        d = {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | 32'h3C;
        r0 = aRises; q0 = aBits.size(); f0 = aFrameLowCycles;
        applyStimulus(0, d, 1, 1);
        waitRx(0, "oob", got, lat);
        checkOutput("oob_rx", got, 32'h0000003C);
        checkOutput("oob_latency", lat, expLatency(CA, 8, 1));
        checkOutput("oob_rises", aRises - r0, 8);
        checkOutput("oob_bits", assemble(0, q0, 8, 1), 32'h3C);
        waitIdle(0);
        checkOutput("oob_frame_never_low", aFrameLowCycles - f0, 0);

        // Two gapless framed words.
        r0 = aRises; f0 = aFrameRises;
        applyStimulus(0, 32'h1, 0, 0);
        waitRx(0, "pair1", got, lat);
        checkOutput("pair1_rx", got, 32'h1);
        applyStimulus(0, 32'h2, 0, 1);
        checkOutput("pair_rxvalid_pulse", rx_valid_a, 0);
        waitRx(0, "pair2", got, lat);
        checkOutput("pair2_rx", got, 32'h2);
        checkOutput("pair2_latency", lat, expLatency(CA, 32, 0));
        checkOutput("pair_frame_held", aFrameRises - f0, 0);
        checkOutput("pair_rises", aRises - r0, 64);
        waitIdle(0);

        // OOB request while a framed series is open.
        d = $urandom;
        applyStimulus(0, d, 0, 0);
        waitRx(0, "mix1", got, lat);
        checkOutput("mix1_rx", got, d);
        r0 = aRises;
        applyStimulus(0, $urandom, 1, 1);
        checkOutput("mix_err_pulse", err_a, 1);
        checkOutput("mix_still_ready", {tx_ready_a, busy_a}, 2'b11);
        @(negedge clk);
        checkOutput("mix_err_single", err_a, 0);
        repeat (4) @(negedge clk);
        checkOutput("mix_no_edges", aRises - r0, 0);
        d2 = $urandom;
        applyStimulus(0, d2, 0, 1);
        waitRx(0, "mix2", got, lat);
        checkOutput("mix2_rx", got, d2);
        checkOutput("mix2_latency", lat, expLatency(CA, 32, 0));
        checkOutput("mix2_rises", aRises - r0, 32);
        waitIdle(0);

        // Random request mix against the transfer-level model.
        open = 0; openOob = 0;
        for (int i = 0; i < 12; i++) begin
            oob  = (i == 11) ? 1'b0 : ($urandom_range(0, 2) == 0);
            last = (i == 11) ? 1'b1 : $urandom_range(0, 1);
            d    = $urandom;
            if (open && !openOob && oob) begin
                applyStimulus(0, d, 1, last);
                checkOutput("rand_err", err_a, 1);
            end else begin
                q0 = aBits.size();
                applyStimulus(0, d, oob, last);
                waitRx(0, "rand", got, lat);
                checkOutput("rand_rx", got, oob ? (d & 32'hFF) : d);
                checkOutput("rand_latency", lat, expLatency(CA, oob ? 8 : 32, !open || (openOob && !oob)));
                checkOutput("rand_bits", assemble(0, q0, oob ? 8 : 32, 1), oob ? (d & 32'hFF) : d);
                open    = !last;
                openOob = oob;
            end
        end
        waitIdle(0);

        // MSB-first instance with miso high and a wider half-period.
        d = $urandom;
        q0 = bBits.size();
        applyStimulus(1, d, 0, 1);
        waitRx(1, "msb", got, lat);
        checkOutput("msb_rx", got, 32'hFFFFFFFF);
        checkOutput("msb_latency", lat, expLatency(CB, 32, 1));
        checkOutput("msb_bits", assemble(1, q0, 32, 0), d);
        waitIdle(1);
        d = $urandom;
        q0 = bBits.size();
        applyStimulus(1, d, 1, 1);
        waitRx(1, "msb_oob", got, lat);
        checkOutput("msb_oob_rx", got, 32'hFF);
        checkOutput("msb_oob_bits", assemble(1, q0, 8, 0), d & 32'hFF);
        waitIdle(1);
        checkOutput("msb_high_min", bHiMin, CB);
        checkOutput("msb_high_max", bHiMax, CB);
        checkOutput("msb_mosi_stable", bUnstable, 0);

        // Reset in the middle of a word.
        r0 = aRises;
        applyStimulus(0, $urandom, 0, 1);
        j = 0;
        while (aRises - r0 < 5 && j < 1000) begin
            @(negedge clk);
            j++;
        end
        checkOutput("midreset_reached", aRises - r0, 5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_cs_frame", {cs_a, frame_a}, 2'b11);
        checkOutput("midreset_sclk_ready", {spi_clk_a, tx_ready_a}, 2'b01);
        rst = 1'b0;
        r0 = aRises;
        j = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_valid_a) j++;
        end
        checkOutput("midreset_no_rxvalid", j, 0);
        checkOutput("midreset_no_rises", aRises - r0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
